// File: rtl/apb_hart_arbiter.sv
// apb_hart_arbiter: two-port round-robin APB arbiter onto one downstream bus; APB_ARB_TIMEOUT_EN adds an access watchdog
module apb_hart_arbiter #(
  parameter int W_PADDR = 16,
  parameter int W_DATA = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s0_psel,
  input  logic               s0_penable,
  input  logic               s0_pwrite,
  input  logic [W_PADDR-1:0] s0_paddr,
  input  logic [W_DATA-1:0]  s0_pwdata,
  input  logic [W_DATA-1:0]  s0_phartid,
  output logic               s0_pready,
  output logic [W_DATA-1:0]  s0_prdata,
  output logic               s0_pslverr,
  input  logic               s1_psel,
  input  logic               s1_penable,
  input  logic               s1_pwrite,
  input  logic [W_PADDR-1:0] s1_paddr,
  input  logic [W_DATA-1:0]  s1_pwdata,
  input  logic [W_DATA-1:0]  s1_phartid,
  output logic               s1_pready,
  output logic [W_DATA-1:0]  s1_prdata,
  output logic               s1_pslverr,
  output logic               m_psel,
  output logic               m_penable,
  output logic               m_pwrite,
  output logic [W_PADDR-1:0] m_paddr,
  output logic [W_DATA-1:0]  m_pwdata,
  output logic [W_DATA-1:0]  m_phartid,
  input  logic               m_pready,
  input  logic [W_DATA-1:0]  m_prdata,
  input  logic               m_pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic [1:0] pend, cap, psel, penable, pwrite, wr_q, err_q;
  logic [1:0][W_PADDR-1:0] paddr, addr_q;
  logic [1:0][W_DATA-1:0] pwdata, phartid, data_q, hart_q, rdata_q;
  logic last_grant, grant, nxt, abort;
  assign psel = {s1_psel, s0_psel};
  assign penable = {s1_penable, s0_penable};
  assign pwrite = {s1_pwrite, s0_pwrite};
  assign paddr = {s1_paddr, s0_paddr};
  assign pwdata = {s1_pwdata, s0_pwdata};
  assign phartid = {s1_phartid, s0_phartid};
  assign cap = psel & ~penable & ~pend;
  assign nxt = &pend ? ~last_grant : pend[1];
  assign m_psel = state == SETUP || state == ACCESS;
  assign m_penable = state == ACCESS;
  assign s0_pready = state == RESP && !grant;
  assign s1_pready = state == RESP && grant;
  assign {s1_prdata, s0_prdata} = rdata_q;
  assign {s1_pslverr, s0_pslverr} = err_q;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign abort = !m_pready && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state != ACCESS) cnt <= '0;
    else if (!m_pready) cnt <= cnt + 1'b1;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pend <= '0;
      last_grant <= 1'b1;
      grant <= 1'b0;
      wr_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      hart_q <= '0;
      rdata_q <= '0;
      err_q <= '0;
      m_pwrite <= 1'b0;
      m_paddr <= '0;
      m_pwdata <= '0;
      m_phartid <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (cap[i]) begin
          pend[i] <= 1'b1;
          wr_q[i] <= pwrite[i];
          addr_q[i] <= paddr[i];
          data_q[i] <= pwdata[i];
          hart_q[i] <= phartid[i];
        end
      case (state)
        IDLE:
          if (|pend) begin
            grant <= nxt;
            last_grant <= nxt;
            m_pwrite <= wr_q[nxt];
            m_paddr <= addr_q[nxt];
            m_pwdata <= data_q[nxt];
            m_phartid <= hart_q[nxt];
            state <= SETUP;
          end
        SETUP: state <= ACCESS;
        ACCESS:
          if (m_pready || abort) begin
            rdata_q[grant] <= m_pready && !m_pwrite ? m_prdata : '0;
            err_q[grant] <= m_pready ? m_pslverr : 1'b1;
            state <= RESP;
          end
        default: begin
          pend[grant] <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_apb_hart_arbiter.sv
// tb_apb_hart_arbiter: randomized scenarios against a queue-based model of two masters and one slave
module tb_apb_hart_arbiter;
  localparam int AW = 16, DW = 32, TO = 8;
  typedef struct {logic w; logic [AW-1:0] a; logic [DW-1:0] d; logic [DW-1:0] h;} req_t;
  typedef struct {logic [DW-1:0] d; logic e;} rsp_t;
  logic clk = 0, rst_n = 1;
  logic s_psel[2], s_penable[2], s_pwrite[2];
  logic [AW-1:0] s_paddr[2];
  logic [DW-1:0] s_pwdata[2], s_phartid[2];
  logic s0_pready, s1_pready, s0_pslverr, s1_pslverr;
  logic [DW-1:0] s0_prdata, s1_prdata;
  logic m_psel, m_penable, m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_phartid;
  logic m_pready = 0, m_pslverr = 0;
  logic [DW-1:0] m_prdata = 0;
  logic [150:0] all_out;
  req_t issued[2][$];
  rsp_t exp_rsp[2][$];
  int order[$];
  int n_pass = 0, n_tot = 0;
  int slv_wait = 0, slv_err = 0;
  bit slv_rand = 0, slv_fix = 0;
  logic [DW-1:0] slv_data = 0;

  always #5 clk = ~clk;

  apb_hart_arbiter #(.W_PADDR(AW), .W_DATA(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_psel(s_psel[0]), .s0_penable(s_penable[0]), .s0_pwrite(s_pwrite[0]),
    .s0_paddr(s_paddr[0]), .s0_pwdata(s_pwdata[0]), .s0_phartid(s_phartid[0]),
    .s0_pready(s0_pready), .s0_prdata(s0_prdata), .s0_pslverr(s0_pslverr),
    .s1_psel(s_psel[1]), .s1_penable(s_penable[1]), .s1_pwrite(s_pwrite[1]),
    .s1_paddr(s_paddr[1]), .s1_pwdata(s_pwdata[1]), .s1_phartid(s_phartid[1]),
    .s1_pready(s1_pready), .s1_prdata(s1_prdata), .s1_pslverr(s1_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_phartid(m_phartid),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr)
  );

  assign all_out = {s0_pready, s0_prdata, s0_pslverr, s1_pready, s1_prdata, s1_pslverr,
                    m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_phartid};

  initial begin
    int w, tgt, p;
    req_t r;
    rsp_t s;
    w = 0;
    tgt = 0;
    forever begin
      @(posedge clk); #1;
      if (m_psel && m_penable) begin
        if (w < tgt) begin
          m_pready = 0;
          w++;
        end else begin
          m_pready = 1;
          m_prdata = slv_fix ? slv_data : $urandom;
          m_pslverr = slv_err == 2 ? 1'($urandom_range(0, 1)) : slv_err == 1;
          p = int'(m_phartid[DW-1]);
          n_tot++;
          if (issued[p].size() == 0) $display("FAIL bus_req port%0d: got unexpected transfer addr %h, want none", p, m_paddr);
          else begin
            r = issued[p].pop_front();
            if ({r.w, r.a, r.d, r.h} !== {m_pwrite, m_paddr, m_pwdata, m_phartid})
              $display("FAIL bus_req port%0d: got %h want %h", p, {m_pwrite, m_paddr, m_pwdata, m_phartid}, {r.w, r.a, r.d, r.h});
            else n_pass++;
          end
          s.d = m_pwrite ? '0 : m_prdata;
          s.e = m_pslverr;
          exp_rsp[p].push_back(s);
          order.push_back(p);
        end
      end else begin
        m_pready = 0;
        m_pslverr = 0;
        w = 0;
        tgt = slv_rand ? int'($urandom_range(0, 3)) : slv_wait;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic rdy(input int i);
    return i ? s1_pready : s0_pready;
  endfunction

  function automatic rsp_t pop_rsp(input int i);
    rsp_t x;
    x.d = 32'hBADC0DE5;
    x.e = 1'b1;
    if (exp_rsp[i].size()) x = exp_rsp[i].pop_front();
    return x;
  endfunction

  task automatic m_xfer(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output logic e, output int n, output int st);
    req_t r;
    @(posedge clk); #1;
    s_psel[i] = 1;
    s_penable[i] = 0;
    s_pwrite[i] = w;
    s_paddr[i] = a;
    s_pwdata[i] = d;
    s_phartid[i] = {1'(i), (DW-1)'($urandom)};
    r.w = w; r.a = a; r.d = d; r.h = s_phartid[i];
    issued[i].push_back(r);
    st = order.size();
    @(posedge clk); #1;
    s_penable[i] = 1;
    n = 1;
    while (!rdy(i) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    rd = i ? s1_prdata : s0_prdata;
    e = i ? s1_pslverr : s0_pslverr;
    n_tot++;
    if (!rdy(i)) $display("FAIL xfer_done port%0d: got no pready after %0d cycles, want pready", i, n);
    else n_pass++;
  endtask

  task automatic m_idle;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      s_psel[i] = 0;
      s_penable[i] = 0;
    end
  endtask

  task automatic do_reset;
    #1 rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      s_psel[i] = 0; s_penable[i] = 0; s_pwrite[i] = 0;
      s_paddr[i] = 0; s_pwdata[i] = 0; s_phartid[i] = 0;
    end
    slv_wait = 0; slv_err = 0; slv_rand = 0; slv_fix = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      issued[i].delete();
      exp_rsp[i].delete();
    end
    order.delete();
    #1 rst_n = 1;
  endtask

  task automatic test_reset;
    #1 rst_n = 0;
    #1;
    n_tot++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out); else n_pass++;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tot++;
    if (all_out !== '0) $display("FAIL idle_outputs: got %h want 0", all_out); else n_pass++;
  endtask

  task automatic test_basic_read;
    logic [DW-1:0] rd; logic e; int n, st; rsp_t x;
    slv_fix = 1;
    slv_data = 32'hDEADBEEF;
    m_xfer(0, 0, 16'h0040, 0, rd, e, n, st);
    x = pop_rsp(0);
    n_tot++;
    if (n !== 4) $display("FAIL read_latency: got %0d want 4", n); else n_pass++;
    n_tot++;
    if ({rd, e} !== {32'hDEADBEEF, 1'b0}) $display("FAIL read_data: got %h/%b want deadbeef/0", rd, e); else n_pass++;
    m_idle();
    repeat (3) @(posedge clk);
    #1;
    n_tot++;
    if ({s0_prdata, s0_pready} !== {32'hDEADBEEF, 1'b0}) $display("FAIL read_hold: got %h/%b want deadbeef/0", s0_prdata, s0_pready); else n_pass++;
    slv_fix = 0;
  endtask

  task automatic test_simultaneous;
    logic [DW-1:0] rd0, rd1; logic e0, e1; int n0, n1, st0, st1; rsp_t x0, x1;
    do_reset();
    fork
      m_xfer(0, 1, 16'h0010, 32'h1234, rd0, e0, n0, st0);
      m_xfer(1, 0, 16'h0020, 0, rd1, e1, n1, st1);
    join
    m_idle();
    x0 = pop_rsp(0);
    x1 = pop_rsp(1);
    n_tot++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1) $display("FAIL sim_order: got %p want '{0, 1}", order); else n_pass++;
    n_tot++;
    if ({n0, n1} !== {32'd4, 32'd8}) $display("FAIL sim_latency: got %0d,%0d want 4,8", n0, n1); else n_pass++;
    n_tot++;
    if ({rd0, e0} !== {32'h0, x0.e}) $display("FAIL sim_write_rsp: got %h/%b want 0/%b", rd0, e0, x0.e); else n_pass++;
    n_tot++;
    if ({rd1, e1} !== {x1.d, x1.e}) $display("FAIL sim_read_rsp: got %h/%b want %h/%b", rd1, e1, x1.d, x1.e); else n_pass++;
  endtask

  task automatic test_back_to_back;
    order.delete();
    slv_rand = 1;
    slv_err = 2;
    fork
      for (int k = 0; k < 6; k++) begin
        logic [DW-1:0] rd; logic e; int n, st; rsp_t x;
        m_xfer(0, 1'($urandom), 16'($urandom), $urandom, rd, e, n, st);
        x = pop_rsp(0);
        n_tot++;
        if ({rd, e} !== {x.d, x.e}) $display("FAIL b2b_rsp0: got %h/%b want %h/%b", rd, e, x.d, x.e); else n_pass++;
      end
      for (int k = 0; k < 6; k++) begin
        logic [DW-1:0] rd; logic e; int n, st; rsp_t x;
        m_xfer(1, 1'($urandom), 16'($urandom), $urandom, rd, e, n, st);
        x = pop_rsp(1);
        n_tot++;
        if ({rd, e} !== {x.d, x.e}) $display("FAIL b2b_rsp1: got %h/%b want %h/%b", rd, e, x.d, x.e); else n_pass++;
      end
    join
    m_idle();
    n_tot++;
    if (order.size() != 12) $display("FAIL b2b_count: got %0d want 12", order.size()); else n_pass++;
    for (int k = 0; k < order.size(); k++) begin
      n_tot++;
      if (order[k] != k % 2) $display("FAIL b2b_alternate[%0d]: got %0d want %0d", k, order[k], k % 2); else n_pass++;
    end
    slv_rand = 0;
    slv_err = 0;
  endtask

  task automatic test_slave_error;
    logic [DW-1:0] rd; logic e; int n, st, p1; rsp_t x;
    slv_wait = 3;
    slv_err = 1;
    p1 = 0;
    fork
      m_xfer(0, 0, 16'h0abc, 0, rd, e, n, st);
      repeat (9) begin
        @(posedge clk); #1;
        if (s1_pready) p1++;
      end
    join
    m_idle();
    x = pop_rsp(0);
    n_tot++;
    if (n !== 7) $display("FAIL err_latency: got %0d want 7", n); else n_pass++;
    n_tot++;
    if ({rd, e} !== {x.d, 1'b1}) $display("FAIL err_rsp: got %h/%b want %h/1", rd, e, x.d); else n_pass++;
    n_tot++;
    if (p1 != 0) $display("FAIL err_other_quiet: got %0d s1 pready pulses want 0", p1); else n_pass++;
    slv_wait = 0;
    slv_err = 0;
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] rd; logic e; int n, st; rsp_t x;
    slv_wait = 1000;
    @(posedge clk); #1;
    s_psel[0] = 1; s_penable[0] = 0; s_pwrite[0] = 0; s_paddr[0] = 16'h0100; s_phartid[0] = 0;
    @(posedge clk); #1;
    s_penable[0] = 1;
    n = 0;
    while (!m_penable && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    n_tot++;
    if (!m_penable) $display("FAIL mid_reach_access: got m_penable=0 want 1"); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_tot++;
    if (all_out !== '0) $display("FAIL mid_async_clear: got %h want 0", all_out); else n_pass++;
    s_psel[0] = 0;
    s_penable[0] = 0;
    issued[0].delete();
    exp_rsp[0].delete();
    order.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    n_tot++;
    if (all_out !== '0) $display("FAIL mid_no_pulse: got %h want 0", all_out); else n_pass++;
    slv_wait = 0;
    m_xfer(0, 0, 16'h0200, 0, rd, e, n, st);
    m_idle();
    x = pop_rsp(0);
    n_tot++;
    if ({n, rd, e} !== {32'd4, x.d, x.e}) $display("FAIL mid_recover: got %0d/%h/%b want 4/%h/%b", n, rd, e, x.d, x.e); else n_pass++;
  endtask

  task automatic test_timeout;
    logic [DW-1:0] rd; logic e; int n, st, acc;
`ifdef APB_ARB_TIMEOUT_EN
    slv_wait = 1000;
    acc = 0;
    fork
      m_xfer(0, 0, 16'h0300, 0, rd, e, n, st);
      repeat (20) begin
        @(posedge clk); #1;
        if (m_psel && m_penable) acc++;
      end
    join
    m_idle();
    issued[0].delete();
    n_tot++;
    if (acc != TO) $display("FAIL to_access_cycles: got %0d want %0d", acc, TO); else n_pass++;
    n_tot++;
    if ({n, rd, e} !== {32'(TO + 3), 32'h0, 1'b1}) $display("FAIL to_abort: got %0d/%h/%b want %0d/0/1", n, rd, e, TO + 3); else n_pass++;
`else
    rsp_t x;
    slv_wait = 20;
    acc = 0;
    m_xfer(0, 0, 16'h0300, 0, rd, e, n, st);
    m_idle();
    x = pop_rsp(0);
    n_tot++;
    if ({n, rd, e} !== {32'd24, x.d, 1'b0}) $display("FAIL long_wait: got %0d/%h/%b want 24/%h/0", n, rd, e, x.d); else n_pass++;
    n_tot++;
    if (acc != 0) $display("FAIL long_wait_acc: got %0d want 0", acc); else n_pass++;
`endif
    slv_wait = 0;
  endtask

  task automatic test_random;
    slv_rand = 1;
    slv_err = 2;
    fork
      for (int k = 0; k < 20; k++) begin
        logic [DW-1:0] rd; logic e; int n, st; rsp_t x;
        m_xfer(0, 1'($urandom), 16'($urandom), $urandom, rd, e, n, st);
        x = pop_rsp(0);
        n_tot++;
        if ({rd, e} !== {x.d, x.e} || order.size() - 1 - st > 1)
          $display("FAIL rand_rsp0: got %h/%b wait %0d want %h/%b wait<=1", rd, e, order.size() - 1 - st, x.d, x.e);
        else n_pass++;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          s_psel[0] = 0; s_penable[0] = 0;
        end
      end
      for (int k = 0; k < 20; k++) begin
        logic [DW-1:0] rd; logic e; int n, st; rsp_t x;
        m_xfer(1, 1'($urandom), 16'($urandom), $urandom, rd, e, n, st);
        x = pop_rsp(1);
        n_tot++;
        if ({rd, e} !== {x.d, x.e} || order.size() - 1 - st > 1)
          $display("FAIL rand_rsp1: got %h/%b wait %0d want %h/%b wait<=1", rd, e, order.size() - 1 - st, x.d, x.e);
        else n_pass++;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          s_psel[1] = 0; s_penable[1] = 0;
        end
      end
    join
    m_idle();
    n_tot++;
    if (issued[0].size() + issued[1].size() != 0) $display("FAIL rand_drained: got %0d outstanding want 0", issued[0].size() + issued[1].size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_simultaneous();
    test_back_to_back();
    test_slave_error();
    test_reset_mid();
    test_timeout();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
